pipelined_segmented_adder: RTL and testbench

- Parametrised, pipelined successor to the fixed-width chained segment adders in the mantissa datapath.
- Splits a WIDTH-bit add/subtract into SEGMENTS carry-chained slices, with one register stage per slice.
- Skews operands in and deskews results out, and adds a valid/ready handshake with backpressure.
- Sits between the Vedic partial-product reduction and normalisation, so the 106-bit product accumulation meets timing at the target clock.

---
 rtl/pipelined_segmented_adder.sv | 124 ++++++++++++
 tb/tb_pipelined_segmented_adder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_segmented_adder.sv
// pipelined_segmented_adder
// WIDTH-bit add/subtract split into SEGMENTS carry-chained slices with one
// register stage per slice. Stage k adds slice k using the carry registered by
// stage k-1. The untouched upper operand bits are skewed forward alongside the
// pipe, and the completed lower result slices accumulate in the stage
// registers, so every output comes straight from a flop. A single global stall
// freezes the whole pipe when the result is held by downstream backpressure.

module pipelined_segmented_adder #(
    parameter int WIDTH    = 52,
    parameter int SEGMENTS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    localparam int SEG_W  = (SEGMENTS > 0) ? ((WIDTH + SEGMENTS - 1) / SEGMENTS) : WIDTH;
    localparam int LAST_W = WIDTH - (SEGMENTS - 1) * SEG_W;

    if ((SEGMENTS < 1) || (SEGMENTS > 8) || (LAST_W <= 0)) begin : g_param_error
        $error("pipelined_segmented_adder: illegal WIDTH/SEGMENTS combination");
    end

    // Whole pipe freezes while a finished result waits for downstream.
    logic stall_s;

    assign stall_s  = out_valid && !out_ready;
    assign in_ready = !stall_s;

    for (genvar k = 0; k < SEGMENTS; k++) begin : g_stage
        localparam int LO = k * SEG_W;                                // first bit of this slice
        localparam int W  = (k == SEGMENTS - 1) ? (WIDTH - LO) : SEG_W; // slice width
        localparam int HI = LO + W;                                   // result bits completed after this stage
        localparam int IW = WIDTH - LO;                               // operand bits still pending at entry

        logic [IW-1:0] a_in_s;
        logic [IW-1:0] bx_in_s;
        logic          c_in_s;
        logic          v_in_s;
        logic [W:0]    slice_s;
        logic [HI-1:0] s_next_s;
        logic [HI-1:0] s_r;
        logic          c_r;
        logic          v_r;

        if (k == 0) begin : g_head
            // Subtraction is a + ~b + 1; the borrow-in is folded into the carry-in.
            assign a_in_s   = a;
            assign bx_in_s  = b ^ {WIDTH{sub}};
            assign c_in_s   = cin ^ sub;
            assign v_in_s   = in_valid;
            assign s_next_s = slice_s[W-1:0];
        end else begin : g_body
            assign a_in_s   = g_stage[k-1].g_fwd.a_r;
            assign bx_in_s  = g_stage[k-1].g_fwd.bx_r;
            assign c_in_s   = g_stage[k-1].c_r;
            assign v_in_s   = g_stage[k-1].v_r;
            assign s_next_s = {slice_s[W-1:0], g_stage[k-1].s_r};
        end

        assign slice_s = {1'b0, a_in_s[W-1:0]} + {1'b0, bx_in_s[W-1:0]} + {{W{1'b0}}, c_in_s};

        // Stage register: completed result bits, slice carry-out and valid bit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= {HI{1'b0}};
            end else if (!stall_s) begin
                v_r <= v_in_s;
                c_r <= slice_s[W];
                s_r <= s_next_s;
            end
        end

        if (k < SEGMENTS - 1) begin : g_fwd
            logic [IW-W-1:0] a_r;
            logic [IW-W-1:0] bx_r;

            // Skew register: upper operand slices ride along untouched.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r  <= {(IW-W){1'b0}};
                    bx_r <= {(IW-W){1'b0}};
                end else if (!stall_s) begin
                    a_r  <= a_in_s[IW-1:W];
                    bx_r <= bx_in_s[IW-1:W];
                end
            end
        end else begin : g_tail
            logic ovf_s;
            logic ovf_r;

            // Carry into the MSB is a^bx^sum at that bit; overflow is it XOR carry-out.
            assign ovf_s = a_in_s[IW-1] ^ bx_in_s[IW-1] ^ slice_s[W-1] ^ slice_s[W];

            // Overflow flag register, aligned with the final result slice.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_r <= 1'b0;
                end else if (!stall_s) begin
                    ovf_r <= ovf_s;
                end
            end
        end
    end

    assign out_valid = g_stage[SEGMENTS-1].v_r;
    assign sum       = g_stage[SEGMENTS-1].s_r;
    assign carry     = g_stage[SEGMENTS-1].c_r;
    assign ovf       = g_stage[SEGMENTS-1].g_tail.ovf_r;

endmodule

// File: tb/tb_pipelined_segmented_adder.sv
// Directed and randomised checks of pipelined_segmented_adder: default build
// for arithmetic, backpressure and reset; three extra builds for the
// parameter sweep.

module tb_pipelined_segmented_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Default build (52, 2)
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, carry, ovf;
    logic [51:0] a, b, sum;

    // Sweep builds share their input controls
    logic         sw_valid, sw_cin, sw_sub;
    logic [105:0] a1, b1, s1;
    logic [52:0]  a2, b2, s2;
    logic [9:0]   a3, b3, s3;
    logic         ir1, ov1, c1, o1;
    logic         ir2, ov2, c2, o2;
    logic         ir3, ov3, c3, o3;

    int n_cmp = 0;
    int n_err = 0;

    pipelined_segmented_adder #(.WIDTH(52), .SEGMENTS(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .carry(carry), .ovf(ovf));

    pipelined_segmented_adder #(.WIDTH(106), .SEGMENTS(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir1),
        .a(a1), .b(b1), .cin(sw_cin), .sub(sw_sub), .out_valid(ov1),
        .out_ready(1'b1), .sum(s1), .carry(c1), .ovf(o1));

    pipelined_segmented_adder #(.WIDTH(53), .SEGMENTS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir2),
        .a(a2), .b(b2), .cin(sw_cin), .sub(sw_sub), .out_valid(ov2),
        .out_ready(1'b1), .sum(s2), .carry(c2), .ovf(o2));

    pipelined_segmented_adder #(.WIDTH(10), .SEGMENTS(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(ir3),
        .a(a3), .b(b3), .cin(sw_cin), .sub(sw_sub), .out_valid(ov3),
        .out_ready(1'b1), .sum(s3), .carry(c3), .ovf(o3));

    task automatic chk(input string tag, input logic [131:0] obs, input logic [131:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {pad, ovf, carry, sum} with sum in the low 128 bits
    function automatic logic [131:0] ref_add(input logic [127:0] ta, input logic [127:0] tb_,
                                             input logic tc, input logic ts, input int w);
        logic [127:0] mask, am, bx, full, s;
        logic         co, ov;
        mask = (128'd1 << w) - 128'd1;
        am   = ta & mask;
        bx   = (ts ? ~tb_ : tb_) & mask;
        full = am + bx + {127'd0, tc ^ ts};
        s    = full & mask;
        co   = full[w];
        ov   = (am[w-1] == bx[w-1]) && (s[w-1] != am[w-1]);
        return {2'b00, ov, co, s};
    endfunction

    // One isolated transaction on the default build; called at a falling edge
    task automatic run_one(input string tag, input logic [51:0] ta, input logic [51:0] tb_,
                           input logic tc, input logic ts,
                           input logic [51:0] es, input logic ec, input logic eo);
        a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".early"}, out_valid, 1'b0);
        @(negedge clk);
        chk({tag, ".valid"}, out_valid, 1'b1);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".carry"}, carry, ec);
        chk({tag, ".ovf"}, ovf, eo);
        @(negedge clk);
    endtask

    logic [51:0]  st_a [10];
    logic [51:0]  st_b [10];
    logic         st_c [10];
    logic         st_s [10];
    logic [131:0] e1 [1000];
    logic [131:0] e2 [1000];
    logic [131:0] e3 [1000];
    logic [3:0]   rpat;
    logic [127:0] ra, rb;
    logic         rc, rs;
    int           sent, got, j;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = 52'd0; b = 52'd0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        sw_valid = 1'b0; sw_cin = 1'b0; sw_sub = 1'b0;
        a1 = 106'd0; b1 = 106'd0; a2 = 53'd0; b2 = 53'd0; a3 = 10'd0; b3 = 10'd0;

        // Reset state
        #2;
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.sum", sum, 52'd0);
        chk("rst.carry", carry, 1'b0);
        chk("rst.ovf", ovf, 1'b0);
        #6 rst_n = 1'b1;
        @(negedge clk);

        // Directed arithmetic
        run_one("carry_cross", 52'hF_FFFF_FFFF_FFFF, 52'd1, 1'b0, 1'b0, 52'd0, 1'b1, 1'b0);
        run_one("sub_neg", 52'd5, 52'd7, 1'b0, 1'b1, 52'hF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_one("sub_pos", 52'd7, 52'd5, 1'b0, 1'b1, 52'd2, 1'b1, 1'b0);
        run_one("sub_borrow", 52'd7, 52'd5, 1'b1, 1'b1, 52'd1, 1'b1, 1'b0);
        run_one("add_cin", 52'd3, 52'd4, 1'b1, 1'b0, 52'd8, 1'b0, 1'b0);
        run_one("signed_ovf", 52'h7_FFFF_FFFF_FFFF, 52'd1, 1'b0, 1'b0, 52'h8_0000_0000_0000, 1'b0, 1'b1);

        // Streaming with backpressure
        for (int i = 0; i < 10; i++) begin
            st_a[i] = {$urandom, $urandom};
            st_b[i] = {$urandom, $urandom};
            st_c[i] = 1'($urandom_range(0, 1));
            st_s[i] = 1'($urandom_range(0, 1));
        end
        rpat = 4'b1001;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            out_ready = rpat[3 - (cyc % 4)];
            in_valid  = (sent < 10);
            if (sent < 10) begin
                a = st_a[sent]; b = st_b[sent]; cin = st_c[sent]; sub = st_s[sent];
            end
            #1;
            if (out_valid && !out_ready) chk("stream.in_ready", in_ready, 1'b0);
            if (out_valid)
                chk("stream.data", {2'b00, ovf, carry, 128'(sum)},
                    ref_add(128'(st_a[got]), 128'(st_b[got]), st_c[got], st_s[got], 52));
            if (out_valid && out_ready) got++;
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        chk("stream.count", got, 10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset with two results in flight
        a = 52'd3; b = 52'd4; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 52'd9; b = 52'd1;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("midrst.inflight", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", out_valid, 1'b0);
        chk("midrst.in_ready", in_ready, 1'b1);
        chk("midrst.sum", sum, 52'd0);
        chk("midrst.carry", carry, 1'b0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst.no_stale", out_valid, 1'b0);
        end

        // Parameter sweep: one vector per cycle into all three builds
        for (int i = 0; i < 1004; i++) begin
            @(negedge clk);
            j = i - 4;
            if (j >= 0 && j < 1000) begin
                chk("sw106.valid", ov1, 1'b1);
                chk("sw106.data", {2'b00, o1, c1, 128'(s1)}, e1[j]);
            end else begin
                chk("sw106.idle", ov1, 1'b0);
            end
            j = i - 1;
            if (j >= 0 && j < 1000) begin
                chk("sw53.valid", ov2, 1'b1);
                chk("sw53.data", {2'b00, o2, c2, 128'(s2)}, e2[j]);
            end else begin
                chk("sw53.idle", ov2, 1'b0);
            end
            j = i - 4;
            if (j >= 0 && j < 1000) begin
                chk("sw10.valid", ov3, 1'b1);
                chk("sw10.data", {2'b00, o3, c3, 128'(s3)}, e3[j]);
            end else begin
                chk("sw10.idle", ov3, 1'b0);
            end
            chk("sw.in_ready", {ir1, ir2, ir3}, 3'b111);
            if (i < 1000) begin
                ra = {$urandom, $urandom, $urandom, $urandom};
                rb = {$urandom, $urandom, $urandom, $urandom};
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                a1 = ra[105:0]; b1 = rb[105:0];
                a2 = ra[52:0];  b2 = rb[52:0];
                a3 = ra[9:0];   b3 = rb[9:0];
                sw_cin = rc; sw_sub = rs; sw_valid = 1'b1;
                e1[i] = ref_add(ra, rb, rc, rs, 106);
                e2[i] = ref_add(ra, rb, rc, rs, 53);
                e3[i] = ref_add(ra, rb, rc, rs, 10);
            end else begin
                sw_valid = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
